seq_divider32: RTL



---
 rtl/alu_pkg.sv | 18 +
 rtl/div_trial_sub.sv | 25 ++
 rtl/seq_divider32.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU datapath blocks.
//   div_state_t : sequencing states of the iterative divider
//   ALU_WIDTH   : default datapath width
//   ALU_OP_DIV  : ALU opcode that selects the divider
package alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_ZERO  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } div_state_t;

    localparam int unsigned ALU_WIDTH  = 32;
    localparam logic [3:0]  ALU_OP_DIV = 4'b1101;

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: combinational (WIDTH+1)-bit trial subtractor for the divider.
// It is built as an adder with the subtrahend inverted and carry-in 1.
// Ports:
//   i_a      [WIDTH:0]    minuend (shifted partial remainder)
//   i_b      [WIDTH:0]    subtrahend (zero-extended divisor)
//   o_diff   [WIDTH-1:0]  low WIDTH bits of i_a - i_b
//   o_borrow              MSB of the (WIDTH+1)-bit difference; 1 means i_a < i_b
module div_trial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH:0] w_sum;

    // The minuend is always below twice the subtrahend, so the MSB of the
    // difference equals the borrow.
    assign w_sum    = i_a + ~i_b + {{WIDTH{1'b0}}, 1'b1};
    assign o_diff   = w_sum[WIDTH-1:0];
    assign o_borrow = w_sum[WIDTH];

endmodule

// File: rtl/seq_divider32.sv
// seq_divider32: iterative restoring divider, one quotient bit per clock, MSB first.
// Optional feature: define SEQ_DIVIDER32_SIGNED_EN to add the signed_op input
// (two's complement operands, with one extra FIXUP cycle on every operation).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         request; sampled only when idle or finishing
//   dividend      numerator, captured on an accepted start
//   divisor       denominator, captured on an accepted start
//   signed_op     (optional) treat operands as two's complement
//   busy          high while the operation is in flight
//   done          one-cycle pulse when results become valid
//   quotient      result, held until the next done
//   remainder     result, held until the next done
//   div_by_zero   last operation had divisor 0
module seq_divider32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER32_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dividend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;

    logic [WIDTH-1:0] w_t;
    logic             w_borrow;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;

`ifdef SEQ_DIVIDER32_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    always_comb begin
        w_dvd_mag = dividend;
        w_dsr_mag = divisor;
        if (signed_op && dividend[WIDTH-1]) w_dvd_mag = '0 - dividend;
        if (signed_op && divisor[WIDTH-1])  w_dsr_mag = '0 - divisor;
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dsr_mag = divisor;
`endif

    div_trial_sub #(
        .WIDTH(WIDTH)
    ) u_trial (
        .i_a      ({r_r, r_q[WIDTH-1]}),
        .i_b      ({1'b0, r_divisor}),
        .o_diff   (w_t),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_divisor   <= '0;
            r_dividend  <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
`ifdef SEQ_DIVIDER32_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // DONE publishes the finished result on the same edge that
                    // may accept the next request, giving back-to-back issue.
                    if (r_state == ST_DONE) begin
                        r_done      <= 1'b1;
                        r_quotient  <= r_q;
                        r_remainder <= r_r;
                        r_dbz       <= r_zero;
                    end
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= w_dsr_mag;
                        r_q        <= w_dvd_mag;
                        r_r        <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_zero     <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef SEQ_DIVIDER32_SIGNED_EN
                        r_neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= signed_op & dividend[WIDTH-1];
`endif
                        r_state    <= (divisor == '0) ? ST_ZERO : ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!w_borrow) begin
                        r_r <= w_t;
                        r_q <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_r <= {r_r[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
`ifdef SEQ_DIVIDER32_SIGNED_EN
                        r_state <= ST_FIXUP;
`else
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                ST_ZERO: begin
                    r_q     <= '1;
                    r_r     <= r_dividend;
                    r_zero  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
`ifdef SEQ_DIVIDER32_SIGNED_EN
                ST_FIXUP: begin
                    if (r_neg_q) r_q <= '0 - r_q;
                    if (r_neg_r) r_r <= '0 - r_r;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
